// File: rtl/mem_banked_pkg.sv
// Shared configuration for the banked memory: default sizes, FSM encoding and
// helpers that derive strobe, index and byte-offset widths from the parameters.
package mem_banked_pkg;

   localparam int unsigned BYTE_BITS      = 8;
   localparam int unsigned MEM_DATA_WIDTH = 64;
   localparam int unsigned MEM_DEPTH      = 1024;

   typedef enum logic [0:0] {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   function automatic int unsigned strb_width(input int unsigned dw);
      return dw / BYTE_BITS;
   endfunction

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned off_width(input int unsigned dw);
      return $clog2(dw / BYTE_BITS);
   endfunction

endpackage

// File: rtl/mem_banked_array.sv
// Word storage with one byte-strobed write port and one synchronous read port.
// The read register doubles as the response data register of the top level.
module mem_banked_array
   import mem_banked_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int unsigned DEPTH      = MEM_DEPTH,
   localparam int unsigned STRB_W    = strb_width(DATA_WIDTH),
   localparam int unsigned IDX_W     = idx_width(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [IDX_W-1:0]      wr_idx,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [STRB_W-1:0]     wr_strb,
   input  logic                  rd_en,
   input  logic                  rd_zero,
   input  logic [IDX_W-1:0]      rd_idx,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem_r [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_r;

   // Byte-strobed write; storage has no reset so contents survive a reset pulse.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int b = 0; b < int'(STRB_W); b++) begin
            if (wr_strb[b]) begin
               mem_r[wr_idx][b*BYTE_BITS +: BYTE_BITS] <= wr_data[b*BYTE_BITS +: BYTE_BITS];
            end
         end
      end
   end

   // Read register: loads on acceptance and holds while the response is stalled.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_r <= {DATA_WIDTH{1'b0}};
      end else if (rd_en) begin
         rd_data_r <= rd_zero ? {DATA_WIDTH{1'b0}} : mem_r[rd_idx];
      end
   end

   assign rd_data = rd_data_r;

endmodule

// File: rtl/mem_banked.sv
// Single-ported word memory behind a valid/ready request and response channel,
// with optional clear-after-reset sequence and address range/alignment checking.
module mem_banked
   import mem_banked_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = MEM_DATA_WIDTH,
   parameter int unsigned DEPTH      = MEM_DEPTH,
   parameter logic [63:0] ADDR_INIT  = 64'h8000_0000,
   parameter bit          INIT_ZERO  = 1'b1
) (
   input  logic                    iClock,
   input  logic                    iReset,
   input  logic                    pReq_iValid,
   output logic                    pReq_oReady,
   input  logic                    pReq_iWrEn,
   input  logic [DATA_WIDTH-1:0]   pReq_iAddr,
   input  logic [DATA_WIDTH-1:0]   pReq_iWrData,
   input  logic [DATA_WIDTH/8-1:0] pReq_iWrStrb,
   output logic                    pRsp_oValid,
   input  logic                    pRsp_iReady,
   output logic [DATA_WIDTH-1:0]   pRsp_oRdData,
   output logic                    pRsp_oErr
);

   localparam int unsigned           STRB_W      = strb_width(DATA_WIDTH);
   localparam int unsigned           IDX_W       = idx_width(DEPTH);
   localparam int unsigned           OFF_W       = off_width(DATA_WIDTH);
   localparam logic [DATA_WIDTH-1:0] BASE        = DATA_WIDTH'(ADDR_INIT);
   localparam logic [DATA_WIDTH-1:0] OFF_MASK    = DATA_WIDTH'(STRB_W - 1);
   localparam logic [IDX_W-1:0]      LAST_IDX    = IDX_W'(DEPTH - 1);
   localparam state_t                RESET_STATE = INIT_ZERO ? ST_INIT : ST_RUN;

   state_t                state_r, state_nxt_s;
   logic [IDX_W-1:0]      init_idx_r, init_idx_nxt_s;
   logic                  en_r;
   logic                  rsp_valid_r, rsp_err_r;
   logic                  ready_s, accept_s, addr_err_s;
   logic [DATA_WIDTH-1:0] addr_off_s, idx_full_s;
   logic                  arr_wr_en_s;
   logic [IDX_W-1:0]      arr_wr_idx_s;
   logic [DATA_WIDTH-1:0] arr_wr_data_s;
   logic [STRB_W-1:0]     arr_wr_strb_s;

   assign addr_off_s = pReq_iAddr - BASE;
   assign idx_full_s = addr_off_s >> OFF_W;
   assign addr_err_s = (pReq_iAddr < BASE) || ((pReq_iAddr & OFF_MASK) != {DATA_WIDTH{1'b0}})
                       || ((idx_full_s >> IDX_W) != {DATA_WIDTH{1'b0}});

   // en_r keeps ready low through reset and rises on the first edge afterwards.
   assign ready_s     = en_r && (state_r == ST_RUN) && (!rsp_valid_r || pRsp_iReady);
   assign accept_s    = pReq_iValid && ready_s;
   assign pReq_oReady = ready_s;

   // State, clear index and enable registers.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         state_r    <= RESET_STATE;
         init_idx_r <= {IDX_W{1'b0}};
         en_r       <= 1'b0;
      end else begin
         state_r    <= state_nxt_s;
         init_idx_r <= init_idx_nxt_s;
         en_r       <= 1'b1;
      end
   end

   // Next state and write-port steering: the clear sequence owns the port in INIT.
   always_comb begin
      state_nxt_s    = state_r;
      init_idx_nxt_s = init_idx_r;
      arr_wr_en_s    = 1'b0;
      arr_wr_idx_s   = idx_full_s[IDX_W-1:0];
      arr_wr_data_s  = pReq_iWrData;
      arr_wr_strb_s  = pReq_iWrStrb;
      case (state_r)
         ST_INIT: begin
            arr_wr_en_s   = 1'b1;
            arr_wr_idx_s  = init_idx_r;
            arr_wr_data_s = {DATA_WIDTH{1'b0}};
            arr_wr_strb_s = {STRB_W{1'b1}};
            if (init_idx_r == LAST_IDX) begin
               state_nxt_s = ST_RUN;
            end else begin
               init_idx_nxt_s = init_idx_r + IDX_W'(1);
            end
         end
         ST_RUN: begin
            arr_wr_en_s = accept_s && pReq_iWrEn && !addr_err_s;
         end
         default: begin
            state_nxt_s = RESET_STATE;
         end
      endcase
   end

   // Response valid/error register; a new acceptance replaces a consumed response.
   always_ff @(posedge iClock or negedge iReset) begin
      if (!iReset) begin
         rsp_valid_r <= 1'b0;
         rsp_err_r   <= 1'b0;
      end else if (accept_s) begin
         rsp_valid_r <= 1'b1;
         rsp_err_r   <= addr_err_s;
      end else if (pRsp_iReady) begin
         rsp_valid_r <= 1'b0;
      end
   end

   assign pRsp_oValid = rsp_valid_r;
   assign pRsp_oErr   = rsp_err_r;

   mem_banked_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_array (
      .clk     (iClock),
      .rst_n   (iReset),
      .wr_en   (arr_wr_en_s),
      .wr_idx  (arr_wr_idx_s),
      .wr_data (arr_wr_data_s),
      .wr_strb (arr_wr_strb_s),
      .rd_en   (accept_s),
      .rd_zero (pReq_iWrEn || addr_err_s),
      .rd_idx  (idx_full_s[IDX_W-1:0]),
      .rd_data (pRsp_oRdData)
   );

endmodule

// File: tb/tb_mem_banked.sv
// Scoreboard bench for mem_banked (DEPTH=16): a byte-level memory model predicts
// each response when the request is accepted; responses are popped as consumed.
module tb_mem_banked;

   localparam int          DW    = 64;
   localparam int          DEPTH = 16;
   localparam logic [63:0] BASE  = 64'h8000_0000;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        valid = 1'b0, wr_en = 1'b0, rsp_ready = 1'b1;
   logic [63:0] addr = 64'd0, wdata = 64'd0;
   logic [7:0]  strb = 8'd0;
   logic        ready, rsp_valid, err;
   logic [63:0] rdata;
   logic        ready0, rsp_valid0, err0;
   logic [63:0] rdata0;
   logic        zero1 = 1'b0;
   logic [63:0] zero64 = 64'd0;
   logic [7:0]  zero8 = 8'd0;

   int          n_checks = 0, n_fail = 0;
   logic [63:0] model_mem [DEPTH];
   logic [64:0] sb_q [$];
   string       cur = "none";
   logic [63:0] last_rd;
   logic        last_err;

   always #5 clk = ~clk;

   mem_banked #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_INIT(BASE), .INIT_ZERO(1'b1)) dut (
      .iClock(clk), .iReset(rst_n), .pReq_iValid(valid), .pReq_oReady(ready),
      .pReq_iWrEn(wr_en), .pReq_iAddr(addr), .pReq_iWrData(wdata), .pReq_iWrStrb(strb),
      .pRsp_oValid(rsp_valid), .pRsp_iReady(rsp_ready), .pRsp_oRdData(rdata), .pRsp_oErr(err));

   mem_banked #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_INIT(BASE), .INIT_ZERO(1'b0)) dut0 (
      .iClock(clk), .iReset(rst_n), .pReq_iValid(zero1), .pReq_oReady(ready0),
      .pReq_iWrEn(zero1), .pReq_iAddr(zero64), .pReq_iWrData(zero64), .pReq_iWrStrb(zero8),
      .pRsp_oValid(rsp_valid0), .pRsp_iReady(zero1), .pRsp_oRdData(rdata0), .pRsp_oErr(err0));

   function automatic logic exp_err(input logic [63:0] a);
      logic [63:0] d;
      if (a < BASE) return 1'b1;
      if (a[2:0] != 3'd0) return 1'b1;
      d = a - BASE;
      if (d >= 64'(8 * DEPTH)) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) model_mem[i] = 64'd0;
      sb_q.delete();
   endtask

   task automatic model_accept();
      logic e;
      int   idx;
      e   = exp_err(addr);
      idx = e ? 0 : int'((addr - BASE) >> 3);
      if (wr_en) begin
         if (!e) begin
            for (int b = 0; b < 8; b++)
               if (strb[b]) model_mem[idx][b*8 +: 8] = wdata[b*8 +: 8];
         end
         sb_q.push_back({e, 64'd0});
      end else begin
         sb_q.push_back({e, e ? 64'd0 : model_mem[idx]});
      end
   endtask

   task automatic step(output bit acc);
      logic [64:0] exp;
      #1;
      acc = valid && ready;
      if (rsp_valid && rsp_ready) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s unexpected_rsp: got err=%0b data=%h, required no response", cur, err, rdata);
         end else begin
            exp = sb_q.pop_front();
            if (rdata !== exp[63:0] || err !== exp[64]) begin
               n_fail++;
               $display("FAIL %s rsp: got err=%0b data=%h, required err=%0b data=%h",
                        cur, err, rdata, exp[64], exp[63:0]);
            end
         end
         last_rd  = rdata;
         last_err = err;
      end
      if (acc) model_accept();
      @(posedge clk);
      #1;
   endtask

   task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d, input logic [7:0] s);
      bit acc;
      valid = 1'b1; wr_en = w; addr = a; wdata = d; strb = s;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) step(acc);
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL %s accept: got ready never high, required accept of %h", cur, a);
      end
      valid = 1'b0;
   endtask

   task automatic drain();
      bit acc;
      for (int i = 0; i < 20 && sb_q.size() != 0; i++) step(acc);
      n_checks++;
      if (sb_q.size() != 0) begin
         n_fail++;
         $display("FAIL %s drain: got %0d responses pending, required 0", cur, sb_q.size());
      end
   endtask

   task automatic wait_init(input bit chk0);
      int cnt;
      cnt   = 0;
      rst_n = 1'b1;
      #1;
      if (!ready) cnt++;
      if (chk0) begin
         n_checks++;
         if (ready0 !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready0_before_edge: got %0b, required 0", cur, ready0);
         end
      end
      @(posedge clk); #1;
      if (chk0) begin
         n_checks++;
         if (ready0 !== 1'b1) begin
            n_fail++;
            $display("FAIL %s ready0_first_edge: got %0b, required 1", cur, ready0);
         end
      end
      for (int i = 0; i < 100 && !ready; i++) begin
         cnt++;
         @(posedge clk); #1;
      end
      n_checks++;
      if (cnt != DEPTH) begin
         n_fail++;
         $display("FAIL %s init_len: got %0d cycles ready low, required %0d", cur, cnt, DEPTH);
      end
      model_clear();
   endtask

   task automatic check_zero(input string tag);
      n_checks++;
      if ({ready, rsp_valid, err, rdata} !== 67'd0) begin
         n_fail++;
         $display("FAIL %s %s: got ready=%0b valid=%0b err=%0b data=%h, required all 0",
                  cur, tag, ready, rsp_valid, err, rdata);
      end
   endtask

   task automatic test_reset();
      cur = "reset";
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check_zero("outputs");
      n_checks++;
      if ({ready0, rsp_valid0, err0, rdata0} !== 67'd0) begin
         n_fail++;
         $display("FAIL %s dut0_outputs: got ready=%0b valid=%0b, required 0", cur, ready0, rsp_valid0);
      end
   endtask

   task automatic test_init();
      cur = "init";
      wait_init(1'b1);
      do_req(1'b0, BASE + 64'h8, 64'd0, 8'h00);
      drain();
      n_checks++;
      if (last_rd !== 64'd0 || last_err !== 1'b0) begin
         n_fail++;
         $display("FAIL %s read_after_init: got err=%0b data=%h, required err=0 data=0", cur, last_err, last_rd);
      end
   endtask

   task automatic test_strobe();
      cur = "strobe";
      do_req(1'b1, BASE, 64'h1122334455667788, 8'hFF);
      do_req(1'b1, BASE, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
      do_req(1'b0, BASE, 64'd0, 8'h00);
      drain();
      n_checks++;
      if (last_rd !== 64'h11223344AAAAAAAA) begin
         n_fail++;
         $display("FAIL %s merged_word: got %h, required 11223344aaaaaaaa", cur, last_rd);
      end
   endtask

   task automatic test_back_to_back();
      logic        tw [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
      logic [63:0] ta [4] = '{BASE + 64'h10, BASE + 64'h10, BASE + 64'h18, BASE + 64'h18};
      logic [63:0] td [4] = '{64'hDEADBEEFCAFEF00D, 64'd0, 64'h0123456789ABCDEF, 64'd0};
      logic [7:0]  ts [4] = '{8'hFF, 8'h00, 8'h3C, 8'h00};
      bit acc;
      cur = "back_to_back";
      rsp_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         valid = 1'b1; wr_en = tw[i]; addr = ta[i]; wdata = td[i]; strb = ts[i];
         step(acc);
         n_checks++;
         if (!acc || rsp_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL %s beat%0d: got accept=%0b valid=%0b, required 1/1", cur, i, acc, rsp_valid);
         end
      end
      valid = 1'b0;
      drain();
   endtask

   task automatic test_errors();
      cur = "errors";
      do_req(1'b0, 64'h7FFF_FFF8, 64'd0, 8'h00);
      do_req(1'b0, BASE + 64'h4, 64'd0, 8'h00);
      do_req(1'b1, BASE + 64'(8 * DEPTH), 64'hFFFFFFFFFFFFFFFF, 8'hFF);
      do_req(1'b1, BASE + 64'h10, 64'hFFFFFFFFFFFFFFFF, 8'h00);
      do_req(1'b0, BASE + 64'h10, 64'd0, 8'h00);
      do_req(1'b0, BASE, 64'd0, 8'h00);
      do_req(1'b0, BASE + 64'(8 * (DEPTH - 1)), 64'd0, 8'h00);
      drain();
   endtask

   task automatic test_backpressure();
      bit          acc;
      logic [63:0] d0;
      logic        e0;
      cur = "backpressure";
      rsp_ready = 1'b0;
      valid = 1'b1; wr_en = 1'b0; addr = BASE; wdata = 64'd0; strb = 8'h00;
      step(acc);
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL %s first_accept: got 0, required 1", cur);
      end
      d0 = rdata; e0 = err;
      addr = 64'h7FFF_FFF8;
      for (int i = 0; i < 5; i++) begin
         n_checks++;
         if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL %s ready_hold%0d: got %0b, required 0", cur, i, ready);
         end
         step(acc);
         n_checks++;
         if (acc || rsp_valid !== 1'b1 || rdata !== d0 || err !== e0) begin
            n_fail++;
            $display("FAIL %s stable%0d: got acc=%0b valid=%0b err=%0b data=%h, required 0/1/%0b/%h",
                     cur, i, acc, rsp_valid, err, rdata, e0, d0);
         end
      end
      rsp_ready = 1'b1;
      step(acc);
      n_checks++;
      if (!acc) begin
         n_fail++;
         $display("FAIL %s release_accept: got 0, required 1", cur);
      end
      valid = 1'b0;
      drain();
   endtask

   task automatic test_reset_mid();
      bit acc;
      cur = "reset_mid";
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (7) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      check_zero("mid_init");
      @(posedge clk); #1;
      wait_init(1'b0);
      do_req(1'b1, BASE + 64'h28, 64'h5555AAAA5555AAAA, 8'hFF);
      drain();
      rsp_ready = 1'b0;
      valid = 1'b1; wr_en = 1'b0; addr = BASE + 64'h28;
      step(acc);
      valid = 1'b0;
      n_checks++;
      if (rsp_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL %s pending_rsp: got valid=%0b, required 1", cur, rsp_valid);
      end
      rst_n = 1'b0;
      #1;
      check_zero("mid_rsp");
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      wait_init(1'b0);
      do_req(1'b0, BASE + 64'h28, 64'd0, 8'h00);
      do_req(1'b1, BASE + 64'h30, 64'h0F0F0F0F0F0F0F0F, 8'hC3);
      do_req(1'b0, BASE + 64'h30, 64'd0, 8'h00);
      drain();
   endtask

   initial begin
      model_clear();
      last_rd  = 64'd0;
      last_err = 1'b0;
      test_reset();
      test_init();
      test_strobe();
      test_back_to_back();
      test_errors();
      test_backpressure();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_banked.md
MEM_BANKED -- requirements
Module: mem_banked

Interface
REQ-001 Parameter DATA_WIDTH, 64, word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, 1024, number of words; SHALL be a power of two, at least 2.
REQ-003 Parameter ADDR_INIT, 64'h8000_0000, byte address of word 0.
REQ-004 Parameter INIT_ZERO, 1; 1 = clear all words after reset, 0 = skip the clear.
REQ-005 iClock  in  1  sole clock; all state changes on its rising edge.
REQ-006 iReset  in  1  reset, asynchronous and active-low.
REQ-007 pReq_iValid  in  1  request valid.
REQ-008 pReq_oReady  out  1  request accepted when Valid and Ready are both high at a clock edge.
REQ-009 pReq_iWrEn  in  1  1 = write, 0 = read.
REQ-010 pReq_iAddr  in  DATA_WIDTH  byte address.
REQ-011 pReq_iWrData  in  DATA_WIDTH  write data.
REQ-012 pReq_iWrStrb  in  DATA_WIDTH/8  byte write strobes; bit k enables byte k.
REQ-013 pRsp_oValid  out  1  response valid.
REQ-014 pRsp_iReady  in  1  response consumed when Valid and Ready are both high.
REQ-015 pRsp_oRdData  out  DATA_WIDTH  read data; 0 for writes and for errors.
REQ-016 pRsp_oErr  out  1  address error flag for this response.

Function
REQ-017 FSM states SHALL be INIT, RUN. Reset enters INIT when INIT_ZERO=1, otherwise RUN.
REQ-018 INIT: one word written to 0 per cycle, index 0..DEPTH-1; pReq_oReady=0; after index DEPTH-1 go to RUN.
- INIT therefore lasts DEPTH cycles after reset release.
REQ-019 RUN: pReq_oReady = !pRsp_oValid || pRsp_iReady.
REQ-020 Index = (pReq_iAddr - ADDR_INIT) >> log2(DATA_WIDTH/8).
REQ-021 Address error SHALL be flagged when any of:
- pReq_iAddr < ADDR_INIT;
- index >= DEPTH;
- byte-offset bits nonzero.
REQ-022 Every accepted request SHALL produce exactly one response, in order.
- Response is registered: pRsp_oValid=1 on the cycle after acceptance.
REQ-023 Accepted read without error: pRsp_oRdData = word contents at the acceptance edge.
- Includes a write accepted on the immediately preceding cycle.
REQ-024 Accepted write without error: at the acceptance edge, update only the bytes whose strobe is set; all other bytes unchanged.
REQ-025 Write with all strobes 0: no memory change; normal response, Err=0.
REQ-026 Any error: no memory change, RdData=0, Err=1.
REQ-027 Response hold: while pRsp_oValid=1 and pRsp_iReady=0, RdData/Err SHALL stay stable and no request is accepted.
REQ-028 Simultaneous consume and accept: the new response replaces the old one on the same edge, allowing full throughput of one request per cycle.
REQ-029 Response consumed with no new request: pRsp_oValid drops to 0 on the next edge.

Reset
REQ-030 Reset assertion in any state, including mid-INIT and mid-response, SHALL immediately force:
- pRsp_oValid=0, pRsp_oRdData=0, pRsp_oErr=0;
- pReq_oReady=0;
- INIT index=0;
- FSM to its reset state.
REQ-031 Memory contents are not reset asynchronously.
- With INIT_ZERO=0, contents after reset are the pre-reset contents.
- An in-flight write is either fully committed or absent.
REQ-032 With INIT_ZERO=0, pReq_oReady SHALL rise on the first clock edge after reset release.

Structure
REQ-033 FSM state encoding, strobe-width and index-width helper constants SHALL live in the shared config package alongside the existing memory and byte-size constants.
REQ-034 The storage array plus strobed write SHALL be one sub-module, mem_banked_array.
- One synchronous read port and one strobed write port.
- FSM, address decode and response register stay in mem_banked.

Verification
REQ-035 INIT_ZERO=1, DEPTH=16: release reset -> pReq_oReady low for exactly 16 cycles; a subsequent read of 0x8000_0008 returns 0, Err=0.
REQ-036 Strobed write: write 0x1122334455667788 with strobe 0xFF to 0x8000_0000, then 0xAAAAAAAAAAAAAAAA with strobe 0x0F, then read -> 0x11223344AAAAAAAA.
REQ-037 Back-to-back write then read of the same address with pRsp_iReady=1 throughout -> read returns the new data; one response per cycle, no bubbles.
REQ-038 Errors: read 0x7FFF_FFF8, read 0x8000_0004, write 0x8000_0000+8*DEPTH -> each gives Err=1, RdData=0, memory unchanged.
REQ-039 Backpressure: hold pRsp_iReady=0 for 5 cycles with pReq_iValid=1 -> pReq_oReady=0 and response stable for all 5 cycles; releasing Ready delivers the responses in order.
REQ-040 Assert iReset during INIT (index 7) and again while pRsp_oValid=1 -> outputs zero immediately; INIT restarts from index 0.
